// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and width defaults for the shift-and-add multiplier
package mult_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
    localparam int MULT_N  = 4;
    localparam int MULT_PW = 2 * MULT_N;
endpackage

// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult: one-partial-product-per-clock unsigned multiplier
// Define MULT_EARLY_TERM_EN to leave CALC once no multiplier bits remain.
module seq_shift_add_mult
    import mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_load,
    input  logic           i_start,
    input  logic [N-1:0]   i_A,
    input  logic [N-1:0]   i_B,
    output logic           o_busy,
    output logic           o_done,
    output logic [2*N-1:0] o_P
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    state_t         r_state, w_nxt;
    logic [N-1:0]   r_op_a, r_op_b;
    logic [2*N-1:0] r_acc, r_p, w_sum;
    logic [CW-1:0]  r_cnt;
    logic           r_busy, r_done, w_last, w_calc, w_ld, w_go;
    assign w_calc = (r_state == CALC);
    assign w_ld   = !w_calc && i_load;
    assign w_go   = !w_calc && i_start;
    assign w_sum  = r_acc + (r_op_b[r_cnt] ? ({{N{1'b0}}, r_op_a} << r_cnt) : '0);
`ifdef MULT_EARLY_TERM_EN
    assign w_last = ((r_op_b >> r_cnt) >> 1) == '0;
`else
    assign w_last = (r_cnt == LAST);
`endif
    always_comb begin
        w_nxt = r_state;
        if (w_calc)
            w_nxt = w_last ? DONE : CALC;
        else
            w_nxt = i_start ? CALC : i_load ? IDLE : r_state;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_p     <= '0;
        end else begin
            r_state <= w_nxt;
            r_busy  <= (w_nxt == CALC);
            if (w_ld) begin
                r_op_a <= i_A;
                r_op_b <= i_B;
            end
            if (w_ld || w_go)
                r_done <= 1'b0;
            if (w_go) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_calc) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_p    <= w_sum;
                    r_done <= 1'b1;
                end
            end
        end
    end
    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_P    = r_p;
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb_seq_shift_add_mult: directed vectors checked against a cycle-level product model
module tb_seq_shift_add_mult;
    logic       clk = 1'b0, rst_n = 1'b1, ld = 1'b0, st = 1'b0;
    logic [3:0] a = '0, b = '0;
    logic       busy, done;
    logic [7:0] p;
    int         tests = 0, fails = 0;
    int         m_left = 0;
    logic [3:0] m_a = '0, m_b = '0;
    logic       m_done = 1'b0;
    logic [7:0] m_p = '0;

    seq_shift_add_mult #(.N(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_load(ld), .i_start(st),
        .i_A(a), .i_B(b), .o_busy(busy), .o_done(done), .o_P(p)
    );

    always #5 clk = ~clk;

    function automatic int lat(input logic [3:0] bv);
`ifdef MULT_EARLY_TERM_EN
        int m = 1;
        for (int i = 0; i < 4; i++) if (bv[i]) m = i + 1;
        return m;
`else
        return 4;
`endif
    endfunction

    // Model: a run takes lat() edges and then presents A*B; inputs are ignored meanwhile.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_a = '0; m_b = '0; m_done = 1'b0; m_p = '0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_p = 8'(m_a * m_b);
                m_done = 1'b1;
            end
        end else begin
            if (ld) begin m_a = a; m_b = b; end
            if (ld || st) m_done = 1'b0;
            if (st) m_left = lat(m_b);
        end
    end

    always @(negedge clk) begin
        tests++;
        if (busy !== (m_left > 0) || done !== m_done || p !== m_p) begin
            fails++;
            $display("FAIL model t=%0t: busy=%b done=%b P=%0d, required busy=%b done=%b P=%0d",
                     $time, busy, done, p, m_left > 0, m_done, m_p);
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_start(input logic [3:0] av, input logic [3:0] bv);
        ld = 1'b1; a = av; b = bv;
        tick();
        ld = 1'b0; st = 1'b1;
        tick();
        st = 1'b0;
    endtask

    task automatic expect_done(input string nm, input int cyc, input logic [7:0] exp);
        repeat (cyc - 1) tick();
        chk({nm, "_busy"}, 8'(busy), 8'd1);
        chk({nm, "_early"}, 8'(done), 8'd0);
        tick();
        chk({nm, "_done"}, 8'(done), 8'd1);
        chk({nm, "_P"}, p, exp);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_P", p, 8'd0);
        load_start(4'd7, 4'd5);
        chk("busy_after_start", 8'(busy), 8'd1);
`ifdef MULT_EARLY_TERM_EN
        expect_done("7x5", 3, 8'd35);
`else
        expect_done("7x5", 4, 8'd35);
`endif
        repeat (3) tick();
        chk("hold_done", 8'(done), 8'd1);
        chk("hold_P", p, 8'd35);
        ld = 1'b1; a = 4'd15; b = 4'd15;
        tick();
        ld = 1'b0;
        chk("load_clears_done", 8'(done), 8'd0);
        chk("load_keeps_P", p, 8'd35);
        st = 1'b1;
        tick();
        st = 1'b0;
        expect_done("15x15", 4, 8'd225);
        load_start(4'd0, 4'd9);
`ifdef MULT_EARLY_TERM_EN
        expect_done("0x9", 4, 8'd0);
`else
        expect_done("0x9", 4, 8'd0);
`endif
        load_start(4'd3, 4'd6);
        ld = 1'b1; st = 1'b1; a = 4'd2; b = 4'd2;
        tick();
        ld = 1'b0; st = 1'b0;
        repeat (3) tick();
        chk("ignore_P", p, 8'd18);
        chk("ignore_done", 8'(done), 8'd1);
        st = 1'b1;
        tick();
        st = 1'b0;
`ifdef MULT_EARLY_TERM_EN
        expect_done("rerun_3x6", 3, 8'd18);
`else
        expect_done("rerun_3x6", 4, 8'd18);
`endif
        ld = 1'b1; st = 1'b1; a = 4'd9; b = 4'd11;
        tick();
        ld = 1'b0; st = 1'b0;
        expect_done("9x11_same", 4, 8'd99);
`ifdef MULT_EARLY_TERM_EN
        load_start(4'd13, 4'd1);
        tick();
        chk("13x1_done", 8'(done), 8'd1);
        chk("13x1_P", p, 8'd13);
        load_start(4'd13, 4'd4);
        expect_done("13x4", 3, 8'd52);
`endif
        load_start(4'd7, 4'd5);
        repeat (2) tick();
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", 8'(busy), 8'd0);
        chk("arst_done", 8'(done), 8'd0);
        chk("arst_P", p, 8'd0);
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("no_done_after_rst", 8'(done), 8'd0);
        chk("no_busy_after_rst", 8'(busy), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
